// File: rtl/me_best_match_search.sv
// Full-search motion-estimation controller: issues every (dx,dy) candidate of a
// +/-RANGE window in raster order and keeps the minimum SAE returned SAE_LAT cycles later.
module me_best_match_search #(
    parameter int RANGE   = 4,
    parameter int SAE_W   = 16,
    parameter int MV_W    = 8,
    parameter int SAE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_cand_valid,
    output logic signed [MV_W-1:0] o_cand_dx,
    output logic signed [MV_W-1:0] o_cand_dy,
    input  logic [SAE_W-1:0]       i_sae_result,
    output logic [SAE_W-1:0]       o_best_sae,
    output logic signed [MV_W-1:0] o_best_dx,
    output logic signed [MV_W-1:0] o_best_dy,
    output logic                   o_done
);

    localparam logic signed [MV_W-1:0] R_POS = MV_W'(RANGE);
    localparam logic signed [MV_W-1:0] R_NEG = -R_POS;
    localparam logic signed [MV_W-1:0] ONE   = MV_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [MV_W-1:0] dx_cnt, dy_cnt;
    logic                   issue, issue_last;

    // Delay line pairing each issued candidate with the SAE that comes back for it.
    logic                   p_valid [SAE_LAT];
    logic                   p_last  [SAE_LAT];
    logic signed [MV_W-1:0] p_dx    [SAE_LAT];
    logic signed [MV_W-1:0] p_dy    [SAE_LAT];

    logic                   have_min;
    logic [SAE_W-1:0]       run_sae;
    logic signed [MV_W-1:0] run_dx, run_dy;

    logic                   consume, take, drain_end;
    logic [SAE_W-1:0]       fin_sae;
    logic signed [MV_W-1:0] fin_dx, fin_dy;

    assign issue      = (state == ISSUE);
    assign issue_last = issue && (dx_cnt == R_POS) && (dy_cnt == R_POS);

    assign consume   = p_valid[SAE_LAT-1];
    // Strictly-smaller update keeps the earliest raster candidate on ties.
    assign take      = consume && (!have_min || (i_sae_result < run_sae));
    assign drain_end = (state == DRAIN) && consume && p_last[SAE_LAT-1];

    assign fin_sae = take ? i_sae_result     : run_sae;
    assign fin_dx  = take ? p_dx[SAE_LAT-1]  : run_dx;
    assign fin_dy  = take ? p_dy[SAE_LAT-1]  : run_dy;

    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign o_cand_valid = issue;
    assign o_cand_dx    = issue ? dx_cnt : '0;
    assign o_cand_dy    = issue ? dy_cnt : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_cnt     <= '0;
            dy_cnt     <= '0;
            have_min   <= 1'b0;
            run_sae    <= '0;
            run_dx     <= '0;
            run_dy     <= '0;
            o_best_sae <= '0;
            o_best_dx  <= '0;
            o_best_dy  <= '0;
            for (int i = 0; i < SAE_LAT; i++) begin
                p_valid[i] <= 1'b0;
                p_last[i]  <= 1'b0;
                p_dx[i]    <= '0;
                p_dy[i]    <= '0;
            end
        end else begin
            if (state == IDLE && i_start) begin
                dx_cnt   <= R_NEG;
                dy_cnt   <= R_NEG;
                have_min <= 1'b0;
            end else if (issue) begin
                if (dx_cnt == R_POS) begin
                    dx_cnt <= R_NEG;
                    dy_cnt <= dy_cnt + ONE;
                end else begin
                    dx_cnt <= dx_cnt + ONE;
                end
            end

            p_valid[0] <= issue;
            p_last[0]  <= issue_last;
            p_dx[0]    <= dx_cnt;
            p_dy[0]    <= dy_cnt;
            for (int i = 1; i < SAE_LAT; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_last[i]  <= p_last[i-1];
                p_dx[i]    <= p_dx[i-1];
                p_dy[i]    <= p_dy[i-1];
            end

            if (take) begin
                have_min <= 1'b1;
                run_sae  <= i_sae_result;
                run_dx   <= p_dx[SAE_LAT-1];
                run_dy   <= p_dy[SAE_LAT-1];
            end

            // Published result includes the final compare, so it is valid in the DONE cycle.
            if (drain_end) begin
                o_best_sae <= fin_sae;
                o_best_dx  <= fin_dx;
                o_best_dy  <= fin_dy;
            end
        end
    end

endmodule

// File: tb/tb_me_best_match_search.sv
// Self-checking bench for me_best_match_search: a large-window instance (RANGE=4, SAE_LAT=2)
// and a small one (RANGE=1, SAE_LAT=3), checked each cycle against a raster/argmin model.
module tb_me_best_match_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start_a, start_b;
    logic [15:0]       sae_in;

    logic              a_busy, a_cv, a_done, b_busy, b_cv, b_done;
    logic signed [7:0] a_cdx, a_cdy, a_bdx, a_bdy, b_cdx, b_cdy, b_bdx, b_bdy;
    logic [15:0]       a_bsae, b_bsae;

    me_best_match_search #(.RANGE(4), .SAE_W(16), .MV_W(8), .SAE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .o_busy(a_busy), .o_cand_valid(a_cv),
        .o_cand_dx(a_cdx), .o_cand_dy(a_cdy), .i_sae_result(sae_in), .o_best_sae(a_bsae),
        .o_best_dx(a_bdx), .o_best_dy(a_bdy), .o_done(a_done)
    );

    me_best_match_search #(.RANGE(1), .SAE_W(16), .MV_W(8), .SAE_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .o_busy(b_busy), .o_cand_valid(b_cv),
        .o_cand_dx(b_cdx), .o_cand_dy(b_cdy), .i_sae_result(sae_in), .o_best_sae(b_bsae),
        .o_best_dx(b_bdx), .o_best_dy(b_bdy), .o_done(b_done)
    );

    int sel = 0;
    logic              m_busy, m_cv, m_done;
    logic signed [7:0] m_cdx, m_cdy, m_bdx, m_bdy;
    logic [15:0]       m_bsae;
    assign m_busy = (sel != 0) ? b_busy : a_busy;
    assign m_cv   = (sel != 0) ? b_cv   : a_cv;
    assign m_done = (sel != 0) ? b_done : a_done;
    assign m_cdx  = (sel != 0) ? b_cdx  : a_cdx;
    assign m_cdy  = (sel != 0) ? b_cdy  : a_cdy;
    assign m_bdx  = (sel != 0) ? b_bdx  : a_bdx;
    assign m_bdy  = (sel != 0) ? b_bdy  : a_bdy;
    assign m_bsae = (sel != 0) ? b_bsae : a_bsae;

    int tests = 0;
    int fails = 0;
    int rand_tab [81];
    int held_sae [2];
    int held_dx  [2];
    int held_dy  [2];
    int obs_valid;
    int obs_done;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sae_of(int m, int dx, int dy, int idx);
        case (m)
            0:       return 10 * (iabs(dx - 1) + iabs(dy + 2)) + 5;
            1:       return ((dx == -3 && dy == 0) || (dx == 2 && dy == 3)) ? 7 : 100;
            2:       return 65535;
            3:       return rand_tab[idx];
            default: return iabs(dx) + iabs(dy);
        endcase
    endfunction

    task automatic check_outputs(string tag, int t, int ev, int edx, int edy, int ebusy,
                                 int edone, int s);
        chk($sformatf("%s_valid_t%0d", tag, t), int'(m_cv), ev);
        chk($sformatf("%s_cdx_t%0d", tag, t), int'(m_cdx), edx);
        chk($sformatf("%s_cdy_t%0d", tag, t), int'(m_cdy), edy);
        chk($sformatf("%s_busy_t%0d", tag, t), int'(m_busy), ebusy);
        chk($sformatf("%s_done_t%0d", tag, t), int'(m_done), edone);
        chk($sformatf("%s_bsae_t%0d", tag, t), int'(m_bsae), held_sae[s]);
        chk($sformatf("%s_bdx_t%0d", tag, t), int'(m_bdx), held_dx[s]);
        chk($sformatf("%s_bdy_t%0d", tag, t), int'(m_bdy), held_dy[s]);
    endtask

    // One search from its start cycle (t=0) through o_done, or through a few cycles after an abort.
    task automatic run_search(input int s, input int r, input int lat, input int m,
                              input int rst_at, input bit extra_start, input string tag);
        int w, n, tend, last_t, bi, bsae, v, k, edx, edy;
        bit ev, aborted;
        w = 2 * r + 1;
        n = w * w;
        tend = n + lat + 1;
        last_t = (rst_at >= 0) ? rst_at + 5 : tend;
        bsae = -1;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            v = sae_of(m, -r + i % w, -r + i / w, i);
            if (bsae < 0 || v < bsae) begin
                bsae = v;
                bi = i;
            end
        end
        sel = s;
        obs_valid = 0;
        obs_done = -1;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            aborted = (rst_at >= 0) && (t > rst_at);
            if (aborted) begin
                held_sae[s] = 0;
                held_dx[s] = 0;
                held_dy[s] = 0;
            end
            ev = !aborted && t >= 1 && t <= n;
            edx = ev ? -r + (t - 1) % w : 0;
            edy = ev ? -r + (t - 1) / w : 0;
            if (!aborted && t == tend) begin
                held_sae[s] = bsae;
                held_dx[s] = -r + bi % w;
                held_dy[s] = -r + bi / w;
            end
            check_outputs(tag, t, int'(ev), edx, edy, int'(!aborted && t >= 1),
                          int'(!aborted && t == tend), s);
            if (m_cv) obs_valid++;
            if (m_done) obs_done = t;
            start_a = (s == 0) && (t == 0 || (extra_start && (t == 10 || t == 83)));
            start_b = (s == 1) && (t == 0 || (extra_start && (t == 10 || t == 83)));
            k = t - lat;
            if (!aborted && k >= 1 && k <= n)
                sae_in = 16'(sae_of(m, -r + (k - 1) % w, -r + (k - 1) / w, k - 1));
            else
                sae_in = 16'($urandom);
            rst = (t == rst_at);
        end
    endtask

    task automatic idle_cycles(input int s, input int cnt, input string tag);
        sel = s;
        for (int t = 0; t < cnt; t++) begin
            @(negedge clk);
            check_outputs(tag, t, 0, 0, 0, 0, 0, s);
            start_a = 1'b0;
            start_b = 1'b0;
            sae_in = 16'($urandom);
        end
    endtask

    task automatic fill_rand(input int hi);
        for (int i = 0; i < 81; i++) rand_tab[i] = $urandom_range(0, hi);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sae_in = 16'h0;
        for (int i = 0; i < 2; i++) begin
            held_sae[i] = 0;
            held_dx[i] = 0;
            held_dy[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 0;
        check_outputs("reset_a", 0, 0, 0, 0, 0, 0, 0);
        sel = 1;
        check_outputs("reset_b", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        idle_cycles(0, 3, "idle0");

        run_search(0, 4, 2, 0, -1, 1'b0, "t1");
        chk("t1_valid_count", obs_valid, 81);
        chk("t1_done_cycle", obs_done, 84);
        chk("t1_best_sae", int'(a_bsae), 5);
        chk("t1_best_dx", int'(a_bdx), 1);
        chk("t1_best_dy", int'(a_bdy), -2);

        idle_cycles(0, 4, "gap1");
        run_search(0, 4, 2, 1, -1, 1'b0, "t2tie");
        chk("t2_tie_sae", int'(a_bsae), 7);
        chk("t2_tie_dx", int'(a_bdx), -3);
        chk("t2_tie_dy", int'(a_bdy), 0);
        run_search(0, 4, 2, 2, -1, 1'b0, "t2max");
        chk("t2_max_sae", int'(a_bsae), 65535);
        chk("t2_max_dx", int'(a_bdx), -4);
        chk("t2_max_dy", int'(a_bdy), -4);

        idle_cycles(0, 3, "gap2");
        run_search(0, 4, 2, 0, 40, 1'b0, "t3rst");
        chk("t3_no_done", obs_done, -1);
        chk("t3_best_zero", int'(a_bsae), 0);
        run_search(0, 4, 2, 0, -1, 1'b0, "t3clean");
        chk("t3_clean_valid_count", obs_valid, 81);

        idle_cycles(0, 2, "gap3");
        run_search(0, 4, 2, 1, -1, 1'b1, "t4a");
        chk("t4_extra_start_done", obs_done, 84);
        fill_rand(500);
        run_search(0, 4, 2, 3, -1, 1'b0, "t4b");
        chk("t4b_valid_count", obs_valid, 81);

        idle_cycles(1, 3, "gap4");
        run_search(1, 1, 3, 4, -1, 1'b0, "t5");
        chk("t5_valid_count", obs_valid, 9);
        chk("t5_done_cycle", obs_done, 13);
        chk("t5_best_sae", int'(b_bsae), 0);
        chk("t5_best_dx", int'(b_bdx), 0);
        chk("t5_best_dy", int'(b_bdy), 0);

        idle_cycles(1, 6, "t6idle_b");
        idle_cycles(0, 6, "t6idle_a");

        for (int it = 0; it < 8; it++) begin
            fill_rand((it % 2 == 0) ? 7 : 65535);
            if (it % 2 == 0)
                run_search(0, 4, 2, 3, -1, 1'b0, $sformatf("rnd%0d_a", it));
            else
                run_search(1, 1, 3, 3, -1, 1'b0, $sformatf("rnd%0d_b", it));
            idle_cycles((it % 2 == 0) ? 0 : 1, $urandom_range(0, 3), $sformatf("rgap%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
